// File: rtl/rd_track_pipe_pkg.sv
// Shared definitions for the destination-register tracking pipeline:
// mode encoding, register index width, latch entry layout and bubble value.
package rd_track_pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_FREEZE  = 2'd1;
    localparam logic [1:0] MODE_FLUSH   = 2'd2;
    localparam logic [1:0] MODE_LOADUSE = 2'd3;

    typedef struct packed {
        logic             reg_wen;
        logic             mem_read;
        logic [REG_W-1:0] rd;
    } stage_t;

    localparam stage_t BUBBLE = '{reg_wen: 1'b0, mem_read: 1'b0, rd: '0};

    // x0 is hardwired to zero, so a load targeting it can never cause a hazard.
    function automatic logic load_use(input stage_t           idex,
                                      input logic [REG_W-1:0] rs1,
                                      input logic [REG_W-1:0] rs2,
                                      input logic             rs1_used,
                                      input logic             rs2_used);
        return idex.mem_read && (idex.rd != '0) &&
               ((rs1_used && (idex.rd == rs1)) || (rs2_used && (idex.rd == rs2)));
    endfunction

endpackage

// File: rtl/rd_track_pipe_if.sv
// Bundle of decode-side inputs and tracking/forwarding outputs of
// rd_track_pipe. master = decode/forwarding side, slave = the tracker.
interface rd_track_pipe_if;
    import rd_track_pipe_pkg::*;

    logic             ID_RegWEN;
    logic             ID_MemRead;
    logic [REG_W-1:0] Rd_ID;
    logic [REG_W-1:0] Rs1_ID_Dec;
    logic [REG_W-1:0] Rs2_ID_Dec;
    logic             Rs1_Used;
    logic             Rs2_Used;
    logic             Flush;
    logic             Mem_Wait;
    logic             Cnt_Clr;

    logic             Stall;
    logic             EX_MEM_RegWEN;
    logic [REG_W-1:0] Rd_EX;
    logic             MEM_WB_RegWEN;
    logic [REG_W-1:0] Rd_MA;
    logic [31:0]      Cnt_LoadUse;
    logic [31:0]      Cnt_Flush;
    logic [31:0]      Cnt_MemWait;

    modport master (
        output ID_RegWEN, ID_MemRead, Rd_ID, Rs1_ID_Dec, Rs2_ID_Dec,
               Rs1_Used, Rs2_Used, Flush, Mem_Wait, Cnt_Clr,
        input  Stall, EX_MEM_RegWEN, Rd_EX, MEM_WB_RegWEN, Rd_MA,
               Cnt_LoadUse, Cnt_Flush, Cnt_MemWait
    );

    modport slave (
        input  ID_RegWEN, ID_MemRead, Rd_ID, Rs1_ID_Dec, Rs2_ID_Dec,
               Rs1_Used, Rs2_Used, Flush, Mem_Wait, Cnt_Clr,
        output Stall, EX_MEM_RegWEN, Rd_EX, MEM_WB_RegWEN, Rd_MA,
               Cnt_LoadUse, Cnt_Flush, Cnt_MemWait
    );

endinterface

// File: rtl/rd_track_pipe_latch.sv
// rd_stage_latch: one pipeline latch entry {RegWEN, MemRead, Rd}.
// Control priority: hold (freeze) over bubble over load.
module rd_stage_latch
    import rd_track_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    // Latch register: reset clears to a bubble, freeze wins over squash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rd_track_pipe.sv
// rd_track_pipe: carries Rd/RegWEN/MemRead through ID/EX, EX/MEM, MEM/WB,
// detects load-use hazards and applies flush and memory-wait freeze.
// Optional macro PERF_CNT_EN adds load-use/flush/mem-wait event counters;
// without it the counter outputs are tied to zero and Cnt_Clr is ignored.
module rd_track_pipe
    import rd_track_pipe_pkg::*;
(
    input logic           clk,
    input logic           rst,
    rd_track_pipe_if.slave bus
);

    stage_t     id_in;
    stage_t     idex_q;
    stage_t     exmem_q;
    stage_t     memwb_q;
    logic       lu;
    logic [1:0] mode;
    logic       freeze;
    logic       idex_bubble;

    assign id_in = '{reg_wen: bus.ID_RegWEN, mem_read: bus.ID_MemRead, rd: bus.Rd_ID};
    assign lu    = load_use(idex_q, bus.Rs1_ID_Dec, bus.Rs2_ID_Dec, bus.Rs1_Used, bus.Rs2_Used);

    // Per-cycle mode: memory wait freezes everything, then flush, then load-use.
    always_comb begin
        mode = MODE_RUN;
        if (bus.Mem_Wait) begin
            mode = MODE_FREEZE;
        end else if (bus.Flush) begin
            mode = MODE_FLUSH;
        end else if (lu) begin
            mode = MODE_LOADUSE;
        end
    end

    assign freeze      = (mode == MODE_FREEZE);
    assign idex_bubble = (mode == MODE_FLUSH) || (mode == MODE_LOADUSE);
    assign bus.Stall   = freeze || (mode == MODE_LOADUSE);

    rd_stage_latch u_idex (
        .clk    (clk),
        .rst    (rst),
        .hold   (freeze),
        .bubble (idex_bubble),
        .d      (id_in),
        .q      (idex_q)
    );

    rd_stage_latch u_exmem (
        .clk    (clk),
        .rst    (rst),
        .hold   (freeze),
        .bubble (1'b0),
        .d      (idex_q),
        .q      (exmem_q)
    );

    rd_stage_latch u_memwb (
        .clk    (clk),
        .rst    (rst),
        .hold   (freeze),
        .bubble (1'b0),
        .d      (exmem_q),
        .q      (memwb_q)
    );

    // MemRead only matters in ID/EX; the downstream copies are dropped.
    logic unused_mem_read;
    assign unused_mem_read = exmem_q.mem_read | memwb_q.mem_read;

    assign bus.EX_MEM_RegWEN = exmem_q.reg_wen;
    assign bus.Rd_EX         = exmem_q.rd;
    assign bus.MEM_WB_RegWEN = memwb_q.reg_wen;
    assign bus.Rd_MA         = memwb_q.rd;

`ifdef PERF_CNT_EN
    logic [31:0] cnt_lu;
    logic [31:0] cnt_fl;
    logic [31:0] cnt_mw;

    // Event counters: clear has priority, each mode bumps its own counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lu <= '0;
            cnt_fl <= '0;
            cnt_mw <= '0;
        end else if (bus.Cnt_Clr) begin
            cnt_lu <= '0;
            cnt_fl <= '0;
            cnt_mw <= '0;
        end else begin
            if (mode == MODE_LOADUSE) cnt_lu <= cnt_lu + 32'd1;
            if (mode == MODE_FLUSH)   cnt_fl <= cnt_fl + 32'd1;
            if (mode == MODE_FREEZE)  cnt_mw <= cnt_mw + 32'd1;
        end
    end

    assign bus.Cnt_LoadUse = cnt_lu;
    assign bus.Cnt_Flush   = cnt_fl;
    assign bus.Cnt_MemWait = cnt_mw;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.Cnt_Clr;
    assign bus.Cnt_LoadUse = 32'd0;
    assign bus.Cnt_Flush   = 32'd0;
    assign bus.Cnt_MemWait = 32'd0;
`endif

endmodule

// File: tb/tb_rd_track_pipe.sv
// Self-checking bench for rd_track_pipe: reference model feeds an expected-
// result queue on every driven cycle, entries are popped after the edge.
module tb_rd_track_pipe;
    import rd_track_pipe_pkg::*;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    rd_track_pipe_if bus ();

    rd_track_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic        ex_w;
        logic [4:0]  ex_rd;
        logic        ma_w;
        logic [4:0]  ma_rd;
        logic [31:0] c_lu;
        logic [31:0] c_fl;
        logic [31:0] c_mw;
    } exp_t;

    exp_t exp_q[$];

    logic        mi_w, mi_m, me_w, mw_w;
    logic [4:0]  mi_rd, me_rd, mw_rd;
    logic [31:0] mc_lu, mc_fl, mc_mw;

    task automatic reset_model();
        mi_w = 0; mi_m = 0; mi_rd = 0;
        me_w = 0; me_rd = 0;
        mw_w = 0; mw_rd = 0;
        mc_lu = 0; mc_fl = 0; mc_mw = 0;
    endtask

    task automatic drive_idle();
        bus.ID_RegWEN = 0; bus.ID_MemRead = 0; bus.Rd_ID = 0;
        bus.Rs1_ID_Dec = 0; bus.Rs2_ID_Dec = 0; bus.Rs1_Used = 0; bus.Rs2_Used = 0;
        bus.Flush = 0; bus.Mem_Wait = 0; bus.Cnt_Clr = 0;
    endtask

    // One clock cycle: drive, check Stall, predict, clock, compare.
    task automatic cycle(input logic wen, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic fl, input logic mwt, input logic clr,
                         output logic st);
        exp_t e;
        logic lu;
        bus.ID_RegWEN = wen; bus.ID_MemRead = mr; bus.Rd_ID = rd;
        bus.Rs1_ID_Dec = rs1; bus.Rs2_ID_Dec = rs2; bus.Rs1_Used = u1; bus.Rs2_Used = u2;
        bus.Flush = fl; bus.Mem_Wait = mwt; bus.Cnt_Clr = clr;
        #1;
        lu = mi_m && (mi_rd != 5'd0) && ((u1 && mi_rd == rs1) || (u2 && mi_rd == rs2));
        st = bus.Stall;
        check("stall", st, mwt || (!fl && lu));
        if (!mwt) begin
            mw_w = me_w; mw_rd = me_rd;
            me_w = mi_w; me_rd = mi_rd;
            if (fl || lu) begin
                mi_w = 0; mi_m = 0; mi_rd = 0;
            end else begin
                mi_w = wen; mi_m = mr; mi_rd = rd;
            end
        end
        if (PERF) begin
            if (clr) begin
                mc_lu = 0; mc_fl = 0; mc_mw = 0;
            end else if (mwt) mc_mw = mc_mw + 1;
            else if (fl)      mc_fl = mc_fl + 1;
            else if (lu)      mc_lu = mc_lu + 1;
        end
        e = '{ex_w: me_w, ex_rd: me_rd, ma_w: mw_w, ma_rd: mw_rd,
              c_lu: mc_lu, c_fl: mc_fl, c_mw: mc_mw};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("ex_wen",  bus.EX_MEM_RegWEN, e.ex_w);
        check("rd_ex",   bus.Rd_EX,         e.ex_rd);
        check("ma_wen",  bus.MEM_WB_RegWEN, e.ma_w);
        check("rd_ma",   bus.Rd_MA,         e.ma_rd);
        check("cnt_lu",  bus.Cnt_LoadUse,   e.c_lu);
        check("cnt_fl",  bus.Cnt_Flush,     e.c_fl);
        check("cnt_mw",  bus.Cnt_MemWait,   e.c_mw);
    endtask

    task automatic nop(input logic clr, output logic st);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, st);
    endtask

    logic s;
    logic r_wen, r_mr, r_u1, r_u2, r_fl, r_mw, r_clr;
    logic [4:0] r_rd, r_rs1, r_rs2;

    initial begin
        drive_idle();
        reset_model();
        #1 rst = 1'b1;
        #1;
        check("rst_rd_ex",  bus.Rd_EX, 0);
        check("rst_ex_wen", bus.EX_MEM_RegWEN, 0);
        check("rst_rd_ma",  bus.Rd_MA, 0);
        check("rst_ma_wen", bus.MEM_WB_RegWEN, 0);
        check("rst_stall",  bus.Stall, 0);
        check("rst_cnt",    bus.Cnt_LoadUse | bus.Cnt_Flush | bus.Cnt_MemWait, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Plain RUN propagation of Rd=5.
        cycle(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, s);
        nop(0, s);
        check("run_rd_ex_2edges", bus.Rd_EX, 5);
        check("run_ex_wen",       bus.EX_MEM_RegWEN, 1);
        nop(0, s);
        check("run_rd_ma_3edges", bus.Rd_MA, 5);
        check("run_ma_wen",       bus.MEM_WB_RegWEN, 1);
        nop(1, s);

        // Load x7 followed by a consumer on rs2.
        cycle(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, s);
        cycle(1, 0, 10, 0, 7, 0, 1, 0, 0, 0, s);
        check("lu_stall", s, 1);
        check("lu_load_in_ex", bus.Rd_EX, 7);
        cycle(1, 0, 10, 0, 7, 0, 1, 0, 0, 0, s);
        check("lu_stall_once", s, 0);
        check("lu_bubble_rd", bus.Rd_EX, 0);
        check("lu_bubble_wen", bus.EX_MEM_RegWEN, 0);
        check("lu_cnt", bus.Cnt_LoadUse, PERF ? 32'd1 : 32'd0);

        // Consumer on rs1.
        cycle(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 0, 11, 3, 0, 1, 0, 0, 0, 0, s);
        check("lu_rs1_stall", s, 1);
        cycle(1, 0, 11, 3, 0, 1, 0, 0, 0, 0, s);

        // No hazard: source unused, and load to x0.
        cycle(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 0, 12, 0, 7, 0, 0, 0, 0, 0, s);
        check("lu_unused_nostall", s, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 0, 13, 0, 0, 1, 1, 0, 0, 0, s);
        check("lu_x0_nostall", s, 0);
        nop(0, s);

        // Load-use and Flush together: flush wins.
        cycle(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, s);
        cycle(1, 0, 14, 0, 7, 0, 1, 1, 0, 0, s);
        check("flu_stall", s, 0);
        check("flu_load_ex", bus.Rd_EX, 7);
        nop(0, s);
        check("flu_bubble_rd", bus.Rd_EX, 0);
        check("flu_bubble_wen", bus.EX_MEM_RegWEN, 0);
        check("flu_cnt_fl", bus.Cnt_Flush, PERF ? 32'd1 : 32'd0);
        check("flu_cnt_lu", bus.Cnt_LoadUse, 0);

        // Three freeze cycles with Rd_EX=9, Rd_MA=4.
        cycle(1, 0, 4, 0, 0, 0, 0, 0, 0, 1, s);
        cycle(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, s);
        nop(0, s);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 12, 0, 0, 0, 0, (i == 1), 1, 0, s);
            check("mw_stall", s, 1);
            check("mw_hold_ex", bus.Rd_EX, 9);
            check("mw_hold_ma", bus.Rd_MA, 4);
        end
        check("mw_cnt", bus.Cnt_MemWait, PERF ? 32'd3 : 32'd0);
        nop(0, s);
        check("mw_release_ex", bus.Rd_EX, 0);
        check("mw_release_ma", bus.Rd_MA, 9);

        // Randomised traffic with a narrow register range to hit matches.
        for (int i = 0; i < 400; i++) begin
            r_wen = 1'($urandom_range(0, 1));
            r_mr  = 1'($urandom_range(0, 1));
            r_rd  = 5'($urandom_range(0, 3));
            r_rs1 = 5'($urandom_range(0, 3));
            r_rs2 = 5'($urandom_range(0, 3));
            r_u1  = 1'($urandom_range(0, 1));
            r_u2  = 1'($urandom_range(0, 1));
            r_fl  = ($urandom_range(0, 7) == 0);
            r_mw  = ($urandom_range(0, 5) == 0);
            r_clr = ($urandom_range(0, 63) == 0);
            cycle(r_wen, r_mr, r_rd, r_rs1, r_rs2, r_u1, r_u2, r_fl, r_mw, r_clr, s);
        end

        // Counter clear.
        nop(1, s);
        check("clr_lu", bus.Cnt_LoadUse, 0);
        check("clr_fl", bus.Cnt_Flush, 0);
        check("clr_mw", bus.Cnt_MemWait, 0);

        // Asynchronous reset mid-stream with all latches valid.
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, s);
        #2 rst = 1'b1;
        #1;
        check("arst_rd_ex",  bus.Rd_EX, 0);
        check("arst_ex_wen", bus.EX_MEM_RegWEN, 0);
        check("arst_rd_ma",  bus.Rd_MA, 0);
        check("arst_ma_wen", bus.MEM_WB_RegWEN, 0);
        check("arst_stall",  bus.Stall, 0);
        reset_model();
        drive_idle();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 0, 6, 0, 0, 0, 0, 0, 0, 0, s);
        nop(0, s);
        nop(0, s);
        check("post_rst_rd_ma", bus.Rd_MA, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
